// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;

endpackage

// File: rtl/seq_shift_matcher.sv
// Serial history register, fill counter and pattern comparator (Mealy match).
module seq_shift_matcher
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift,
    input  logic             x,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             match
);

    localparam int FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  window;

    // Window is the last PAT_W-1 bits plus the bit arriving this cycle.
    assign window = {hist, x};
    assign match  = shift && (fill == FILL_MAX) && (window == pattern);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= window[PAT_W-2:0];
            if (match && !overlap)
                fill <= '0;
            else if (fill != FILL_MAX)
                fill <= fill + 1'b1;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Pattern detector controller: config handshake, arm/abort FSM, match counter.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic             start,
    input  logic             abort,
    input  logic             x,
    input  logic             x_valid,
    output logic             y,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nx;
    logic [PAT_W-1:0] pattern_q;
    logic             overlap_q;
    logic [CNT_W-1:0] limit_q;
    logic             cfg_loaded;
    logic             cfg_take;
    logic             arm;
    logic             shift;
    logic             match;
    logic [CNT_W-1:0] cnt_inc;

    seq_shift_matcher #(.PAT_W(PAT_W)) u_matcher (
        .clk     (clk),
        .reset   (reset),
        .clr     (arm),
        .shift   (shift),
        .x       (x),
        .pattern (pattern_q),
        .overlap (overlap_q),
        .match   (match)
    );

    assign cnt_inc = (match_count == '1) ? match_count : match_count + 1'b1;
    assign y       = match;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // A config offer in the same cycle as start wins; start is dropped.
    always_comb begin
        state_nx  = state;
        cfg_ready = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        cfg_take  = 1'b0;
        arm       = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                cfg_take = cfg_valid;
                arm      = start && !cfg_valid && cfg_loaded;
                if (arm) state_nx = ARMED;
            end
            ARMED: begin
                cfg_ready = 1'b0;
                busy      = 1'b1;
                shift     = x_valid && !abort;
                if (abort)
                    state_nx = IDLE;
                else if (match && (limit_q != '0) && (cnt_inc == limit_q))
                    state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                cfg_take = cfg_valid;
                arm      = start && !cfg_valid && !abort;
                if (abort)    state_nx = IDLE;
                else if (arm) state_nx = ARMED;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern_q  <= '0;
            overlap_q  <= 1'b0;
            limit_q    <= '0;
            cfg_loaded <= 1'b0;
        end else if (cfg_take) begin
            pattern_q  <= cfg_pattern;
            overlap_q  <= cfg_overlap;
            limit_q    <= cfg_limit;
            cfg_loaded <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     match_count <= '0;
        else if (arm)   match_count <= '0;
        else if (match) match_count <= cnt_inc;
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl; second instance with CNT_W=2 covers saturation.
module tb_seq_det_ctrl;
    import seq_det_pkg::*;

    logic       clk, reset;
    logic       cfg_valid, cfg_overlap, start, abort, x, x_valid;
    logic [3:0] cfg_pattern;
    logic [7:0] cfg_limit;
    logic       cfg_ready, y, busy, done;
    logic [7:0] match_count;
    logic       cfg_ready2, y2, busy2, done2;
    logic [1:0] match_count2;

    int errors = 0;
    int checks = 0;

    seq_det_ctrl #(.PAT_W(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cfg_limit(cfg_limit),
        .start(start), .abort(abort), .x(x), .x_valid(x_valid), .y(y),
        .match_count(match_count), .busy(busy), .done(done)
    );

    seq_det_ctrl #(.PAT_W(4), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
        .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cfg_limit(cfg_limit[1:0]),
        .start(start), .abort(abort), .x(x), .x_valid(x_valid), .y(y2),
        .match_count(match_count2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [3:0] pat, input logic ov, input logic [7:0] lim);
        cfg_valid   = 1'b1;
        cfg_pattern = pat;
        cfg_overlap = ov;
        cfg_limit   = lim;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic b, input logic exp_y, input string tag);
        x       = b;
        x_valid = 1'b1;
        #2;
        check({tag, ".y"}, y, exp_y);
        check({tag, ".y_sat"}, y2, exp_y);
        tick();
        x_valid = 1'b0;
    endtask

    task automatic gap();
        x_valid = 1'b0;
        x       = 1'b1;
        tick();
    endtask

    // Stream 1,1,0,1,1,0,1 with expected y per bit given as a 7-bit mask (bit 6 first).
    task automatic stream7(input logic [6:0] ymask, input string tag);
        logic [6:0] bits;
        bits = 7'b1101101;
        for (int i = 6; i >= 0; i--)
            send(bits[i], ymask[i], $sformatf("%s.b%0d", tag, 7 - i));
    endtask

    initial begin
        reset = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0;
        cfg_limit = '0; start = 1'b0; abort = 1'b0; x = 1'b0; x_valid = 1'b0;
        #12;
        check("rst.cfg_ready", cfg_ready, 1);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.y", y, 0);
        check("rst.count", match_count, 0);
        @(negedge clk) reset = 1'b1;
        tick();

        // start without any config stays idle
        do_start();
        check("nocfg.busy", busy, 0);
        check("nocfg.cfg_ready", cfg_ready, 1);

        // overlapping matches
        do_cfg(DEFAULT_PATTERN, 1'b1, 8'd0);
        check("cfg.busy", busy, 0);
        do_start();
        check("ovl.busy", busy, 1);
        check("ovl.cfg_ready", cfg_ready, 0);
        stream7(7'b0001001, "ovl");
        check("ovl.count", match_count, 2);
        check("ovl.busy2", busy, 1);

        // config offered while armed is refused
        cfg_valid = 1'b1; cfg_pattern = 4'b0000; cfg_overlap = 1'b0; cfg_limit = 8'd1;
        #2 check("armcfg.cfg_ready", cfg_ready, 0);
        tick();
        cfg_valid = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort.busy", busy, 0);
        check("abort.count_hold", match_count, 2);

        // re-arm; pattern must still be 1101, gaps must not break the match
        do_start();
        check("rearm.count", match_count, 0);
        send(1'b1, 1'b0, "gap.b1");
        gap();
        send(1'b1, 1'b0, "gap.b2");
        gap(); gap();
        send(1'b0, 1'b0, "gap.b3");
        send(1'b1, 1'b1, "gap.b4");
        check("gap.count", match_count, 1);

        // non-overlapping
        abort = 1'b1; tick(); abort = 1'b0;
        do_cfg(4'b1101, 1'b0, 8'd0);
        do_start();
        stream7(7'b0001000, "novl");
        check("novl.count", match_count, 1);

        // limit of 2
        abort = 1'b1; tick(); abort = 1'b0;
        do_cfg(4'b1101, 1'b1, 8'd2);
        do_start();
        stream7(7'b0001001, "lim");
        check("lim.done", done, 1);
        check("lim.busy", busy, 0);
        check("lim.count", match_count, 2);
        check("lim.cfg_ready", cfg_ready, 1);
        send(1'b1, 1'b0, "limx.b1");
        send(1'b1, 1'b0, "limx.b2");
        send(1'b0, 1'b0, "limx.b3");
        send(1'b1, 1'b0, "limx.b4");
        check("limx.count", match_count, 2);
        do_start();
        check("limre.busy", busy, 1);
        check("limre.done", done, 0);
        check("limre.count", match_count, 0);

        // abort coincident with a would-be match
        send(1'b1, 1'b0, "ab.b1");
        send(1'b1, 1'b0, "ab.b2");
        send(1'b0, 1'b0, "ab.b3");
        send(1'b1, 1'b1, "ab.b4");
        send(1'b1, 1'b0, "ab.b5");
        send(1'b0, 1'b0, "ab.b6");
        x = 1'b1; x_valid = 1'b1; abort = 1'b1;
        #2 check("ab.y_gated", y, 0);
        tick();
        x_valid = 1'b0; abort = 1'b0;
        check("ab.busy", busy, 0);
        check("ab.count", match_count, 1);

        // config and start together in IDLE: config wins
        cfg_valid = 1'b1; start = 1'b1; cfg_limit = 8'd0;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        check("cfgstart.busy", busy, 0);
        check("cfgstart.count", match_count, 1);

        // asynchronous reset mid-armed
        do_start();
        send(1'b1, 1'b0, "rs.b1");
        send(1'b1, 1'b0, "rs.b2");
        send(1'b0, 1'b0, "rs.b3");
        send(1'b1, 1'b1, "rs.b4");
        check("rs.pre_count", match_count, 1);
        #2 reset = 1'b0;
        #1;
        check("rs.busy", busy, 0);
        check("rs.count", match_count, 0);
        check("rs.cfg_ready", cfg_ready, 1);
        check("rs.y", y, 0);
        #1 reset = 1'b1;
        do_start();
        check("rs.start_ignored", busy, 0);

        // saturation: five overlapping matches
        do_cfg(4'b1101, 1'b1, 8'd0);
        do_start();
        begin
            logic [15:0] sb, sy;
            sb = 16'b1101101101101101;
            sy = 16'b0001001001001001;
            for (int i = 15; i >= 0; i--)
                send(sb[i], sy[i], $sformatf("sat.b%0d", 16 - i));
        end
        check("sat.count8", match_count, 5);
        check("sat.count2", match_count2, 3);
        check("sat.busy2", busy2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
